reset_sequencer: RTL
====================

# reset_sequencer

Parametrised system reset controller: merges power-on, FPGA-start, debounced push-button and software reset requests into one hold interval, then releases up to NUM_OUT low-active domain resets in a fixed, staggered order (e.g. clocks, then VIC/SID, then CPU). It sits at the top of the design, fed by the raw board signals, and drives every other block's reset. It reports the cause of the last reset and whether a sequence is in progress.

## Interface
- HOLD_CYCLES, 5_000_000, clk cycles all outputs stay asserted after the last trigger (500 ms at 10 MHz); ≥1
- STAGGER_CYCLES, 1000, clk cycles between releases of consecutive outputs; ≥1
- NUM_OUT, 3, number of sequenced reset outputs; 1..8
- DEBOUNCE_CYCLES, 100_000, consecutive cycles fpga_but1 must read low to count as pressed (10 ms); ≥1
- clk  in  1  system clock (10 MHz std fpga clk)
- reset  in  1  synchronous, active-high reset of this block
- fpga_but1  in  1  board button, active-low, asynchronous
- fpgaStart  in  1  low while FPGA programming/start-up incomplete, asynchronous
- sw_req  in  1  single-cycle software reset request, synchronous to clk
- reset_n  out  NUM_OUT  domain resets, low active; bit 0 released first
- busy  out  1  high while any reset_n bit is low
- cause  out  2  last reset source: 00 reset input, 01 fpgaStart, 10 button, 11 software

## Operation
- fpga_but1 and fpgaStart each pass a 2-FF synchroniser (initial value 1) before use.
- Debounce: counter increments while synced button is low, clears when high; press = counter reached DEBOUNCE_CYCLES (saturates). Press is a level: held button keeps the block in HOLD.
- Trigger = press OR synced fpgaStart low OR sw_req. Cause priority if simultaneous: fpgaStart > button > software.
- States: HOLD, STAGGER, RUN.
- HOLD: all reset_n = 0; hold counter increments each cycle without trigger; trigger clears counter to 0 and updates cause. After HOLD_CYCLES trigger-free cycles, reset_n[0] rises, stagger counter and index clear, go to STAGGER (or RUN if NUM_OUT=1).
- STAGGER: every STAGGER_CYCLES cycles the next reset_n bit rises; when bit NUM_OUT-1 rises go to RUN. Any trigger: all reset_n = 0, counters clear, cause updated, go to HOLD.
- RUN: all reset_n = 1, busy = 0. Trigger: all reset_n = 0 next edge, cause updated, go to HOLD.
- Released bits never re-assert individually; assertion is always all bits at once.
- Counter widths via $clog2 of parameter+1; no wrap possible (counters stop at terminal value).

## Timing
- reset = 1 (sampled at clk edge): state HOLD, all counters 0, synchronisers 1, reset_n = all 0, busy = 1, cause = 00. Dominates every other input.
- All outputs registered. Cycle 1 = first edge with reset = 0 and no trigger. reset_n[0] = 1 after edge HOLD_CYCLES; reset_n[k] = 1 after edge HOLD_CYCLES + k·STAGGER_CYCLES; busy falls on the same edge as reset_n[NUM_OUT-1].
- sw_req in RUN: reset_n all 0 and cause = 11 after the next edge (1-cycle latency).
- fpgaStart low: 2 synchroniser cycles + 1 edge to reset_n assertion. Button: 2 + DEBOUNCE_CYCLES + 1.
- Button glitch shorter than DEBOUNCE_CYCLES: no effect.
- Trigger on the same edge as the HOLD→STAGGER or last-bit release: trigger wins, outputs stay/return to 0, state HOLD.

## Test plan
- Params HOLD=20, STAGGER=4, NUM_OUT=3, DEBOUNCE=8; deassert reset, inputs idle → reset_n 000→001 after edge 20, 011 after 24, 111 and busy=0 after 28, cause=00.
- In RUN pulse sw_req one cycle → reset_n=000 and cause=11 next edge; full release sequence repeats 20/24/28 edges later.
- Button low 5 cycles → no reset; button low 30 cycles → reset_n=000 after 2+8+1 edges, cause=10, release starts 20 edges after button synced high.
- fpgaStart low during STAGGER (reset_n=001) → 000 within 3 edges, cause=01, hold restarts from 0.
- fpgaStart low and sw_req same cycle in RUN → cause=11 first (sw sync path faster), then 01 after synchroniser; release 20 edges after fpgaStart synced high.
- Assert reset mid-STAGGER → reset_n=000, busy=1, cause=00 next edge; NUM_OUT=1 run: reset_n[0] and busy=0 after edge 20.

Source files
------------

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// System reset controller. Merges four reset requests into one hold interval,
// then releases NUM_OUT low-active domain resets one after another, bit 0
// first, with STAGGER_CYCLES between consecutive releases.
//
// Request sources:
//   - reset      : synchronous active-high reset of this block itself
//   - fpgaStart  : low while FPGA start-up is incomplete (asynchronous)
//   - fpga_but1  : board push-button, active-low, debounced (asynchronous)
//   - sw_req     : single-cycle software request (synchronous to clk)
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset, dominates everything
//   fpga_but1  in   push-button, low = pressed
//   fpgaStart  in   low = start-up not complete
//   sw_req     in   one-cycle software reset request
//   reset_n    out  [NUM_OUT-1:0] domain resets, low active, bit 0 first
//   busy       out  high while any reset_n bit is low
//   cause      out  last source: 00 reset, 01 fpgaStart, 10 button, 11 sw
// -----------------------------------------------------------------------------
module reset_sequencer #(
   parameter int HOLD_CYCLES     = 5_000_000,
   parameter int STAGGER_CYCLES  = 1000,
   parameter int NUM_OUT         = 3,
   parameter int DEBOUNCE_CYCLES = 100_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fpga_but1,
   input  logic               fpgaStart,
   input  logic               sw_req,
   output logic [NUM_OUT-1:0] reset_n,
   output logic               busy,
   output logic [1:0]         cause
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int STAG_W = $clog2(STAGGER_CYCLES + 1);
   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_STAGGER = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   // synchronisers and debounce
   logic              r_but_meta;
   logic              r_but_sync;
   logic              r_start_meta;
   logic              r_start_sync;
   logic [DEB_W-1:0]  r_deb_cnt;

   // sequencer state
   state_t            r_state;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [STAG_W-1:0] r_stag_cnt;
   logic [NUM_OUT-1:0] r_reset_n;
   logic              r_busy;
   logic [1:0]        r_cause;

   state_t             w_state_next;
   logic [HOLD_W-1:0]  w_hold_cnt_next;
   logic [STAG_W-1:0]  w_stag_cnt_next;
   logic [NUM_OUT-1:0] w_reset_n_next;
   logic               w_busy_next;
   logic [1:0]         w_cause_next;

   logic               w_press;
   logic               w_start_req;
   logic               w_trigger;
   logic [1:0]         w_trig_cause;
   logic [NUM_OUT-1:0] w_step_rn;

   // Synchronisers idle at 1 (inactive). The debounce counter saturates at
   // DEBOUNCE_CYCLES so a held button stays a continuous press.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_but_meta   <= 1'b1;
         r_but_sync   <= 1'b1;
         r_start_meta <= 1'b1;
         r_start_sync <= 1'b1;
         r_deb_cnt    <= '0;
      end else begin
         r_but_meta   <= fpga_but1;
         r_but_sync   <= r_but_meta;
         r_start_meta <= fpgaStart;
         r_start_sync <= r_start_meta;
         if (r_but_sync) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt != DEB_W'(DEBOUNCE_CYCLES)) begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
         end
      end
   end

   assign w_press     = (r_deb_cnt == DEB_W'(DEBOUNCE_CYCLES));
   assign w_start_req = ~r_start_sync;
   assign w_trigger   = w_press | w_start_req | sw_req;
   // fpgaStart outranks the button, which outranks software
   assign w_trig_cause = w_start_req ? 2'b01 :
                         w_press     ? 2'b10 : 2'b11;

   // reset_n is a thermometer code (released bits are a contiguous run from
   // bit 0), so the next release step is each bit OR-ed with its lower
   // neighbour, with bit 0 forced released.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : g_step
         if (gi == 0) begin : g_first
            assign w_step_rn[gi] = 1'b1;
         end else begin : g_next
            assign w_step_rn[gi] = r_reset_n[gi] | r_reset_n[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_HOLD;
         r_hold_cnt <= '0;
         r_stag_cnt <= '0;
         r_reset_n  <= '0;
         r_busy     <= 1'b1;
         r_cause    <= 2'b00;
      end else begin
         r_state    <= w_state_next;
         r_hold_cnt <= w_hold_cnt_next;
         r_stag_cnt <= w_stag_cnt_next;
         r_reset_n  <= w_reset_n_next;
         r_busy     <= w_busy_next;
         r_cause    <= w_cause_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_hold_cnt_next = r_hold_cnt;
      w_stag_cnt_next = r_stag_cnt;
      w_reset_n_next  = r_reset_n;
      w_cause_next    = r_cause;

      // A trigger in any state wins over a release due on the same edge.
      if (w_trigger) begin
         w_state_next    = ST_HOLD;
         w_hold_cnt_next = '0;
         w_stag_cnt_next = '0;
         w_reset_n_next  = '0;
         w_cause_next    = w_trig_cause;
      end else begin
         case (r_state)
            ST_HOLD: begin
               w_reset_n_next = '0;
               if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                  w_reset_n_next  = NUM_OUT'(1);
                  w_hold_cnt_next = '0;
                  w_stag_cnt_next = '0;
                  w_state_next    = (NUM_OUT == 1) ? ST_RUN : ST_STAGGER;
               end else begin
                  w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
               end
            end
            ST_STAGGER: begin
               if (r_stag_cnt == STAG_W'(STAGGER_CYCLES - 1)) begin
                  w_reset_n_next  = w_step_rn;
                  w_stag_cnt_next = '0;
                  if (&w_step_rn) begin
                     w_state_next = ST_RUN;
                  end
               end else begin
                  w_stag_cnt_next = r_stag_cnt + STAG_W'(1);
               end
            end
            ST_RUN: begin
               w_reset_n_next = '1;
            end
            default: begin
               w_state_next    = ST_HOLD;
               w_hold_cnt_next = '0;
               w_stag_cnt_next = '0;
               w_reset_n_next  = '0;
            end
         endcase
      end

      w_busy_next = ~(&w_reset_n_next);
   end

   assign reset_n = r_reset_n;
   assign busy    = r_busy;
   assign cause   = r_cause;

endmodule
